pc_next_unit: RTL and testbench

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_unit.sv | 67 ++++++
 tb/tb_pc_next_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter sequencing with jump/branch targets, misalignment fault and redirect counting.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  JumpOP,
    input  logic [31:0] ins,
    input  logic [31:0] rs_data,
    input  logic        fetch_ready,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_req,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [15:0] redirect_count
);
    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, fault_pc_q, fault_pc_d, target;
    logic [15:0] rc_q, rc_d;
    logic        advance;
    logic        unused_ins;
    assign unused_ins     = ^ins[31:26];
    assign pc_plus4       = pc_q + 32'd4;
    assign pc             = pc_q;
    assign fault_pc       = fault_pc_q;
    assign redirect_count = rc_q;
    assign fetch_req      = state_q == FETCH;
    assign fault          = state_q == FAULT;
    always_comb begin
        target = JumpOP == 2'd0 ? {pc_plus4[31:28], ins[25:0], 2'b00} :
                 JumpOP == 2'd1 ? rs_data :
                 JumpOP == 2'd2 ? pc_plus4 + {{14{ins[15]}}, ins[15:0], 2'b00} : pc_plus4;
        advance    = state_q == FETCH && fetch_ready && !stall;
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        rc_d       = rc_q;
        if (state_q == IDLE) begin
            state_d = FETCH;
        end else if (advance) begin
            // a misaligned target freezes the pc and parks the unit until reset
            if (|target[1:0]) begin
                fault_pc_d = target;
                state_d    = FAULT;
            end else begin
                pc_d = target;
                if (JumpOP != 2'd3 && rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0;
            rc_q       <= 16'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            rc_q       <= rc_d;
        end
    end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed checks of pc sequencing, targets, hold, fault, wrap, saturation and reset.
module tb_pc_next_unit;
    logic        clk, rst, fetch_ready, stall;
    logic [1:0]  JumpOP;
    logic [31:0] ins, rs_data, pc, pc_plus4, fault_pc;
    logic        fetch_req, fault;
    logic [15:0] redirect_count;
    int          checks = 0;
    int          failures = 0;

    pc_next_unit dut (
        .clk(clk), .rst(rst), .JumpOP(JumpOP), .ins(ins), .rs_data(rs_data),
        .fetch_ready(fetch_ready), .stall(stall), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_req(fetch_req), .fault(fault), .fault_pc(fault_pc),
        .redirect_count(redirect_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; JumpOP = 2'd3; ins = 32'h0; rs_data = 32'h0; fetch_ready = 1; stall = 0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_freq", {31'h0, fetch_req}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_fpc", fault_pc, 32'h0);
        chk("rst_rc", {16'h0, redirect_count}, 32'h0);
        step();
        rst = 0;
        step();
        chk("idle_pc", pc, 32'h0);
        chk("fetch_req_on", {31'h0, fetch_req}, 32'h1);
        step();
        chk("seq_4", pc, 32'h4);
        step();
        chk("seq_8", pc, 32'h8);
        chk("seq_rc", {16'h0, redirect_count}, 32'h0);
        chk("plus4", pc_plus4, 32'hC);
        JumpOP = 2'd1; rs_data = 32'h100;
        step();
        chk("jr_100", pc, 32'h100);
        chk("jr_rc", {16'h0, redirect_count}, 32'h1);
        JumpOP = 2'd2; ins = 32'h0000_FFFE;
        step();
        chk("br_back", pc, 32'h0FC);
        chk("br_rc", {16'h0, redirect_count}, 32'h2);
        JumpOP = 2'd1;
        step();
        JumpOP = 2'd2; ins = 32'h0000_0003;
        step();
        chk("br_fwd", pc, 32'h110);
        JumpOP = 2'd1; rs_data = 32'hA000_0000;
        step();
        JumpOP = 2'd0; ins = 32'h0000_0010;
        step();
        chk("j_tgt", pc, 32'hA000_0040);
        JumpOP = 2'd1; rs_data = 32'h2000;
        step();
        chk("jr_2000", pc, 32'h2000);
        chk("rc_7", {16'h0, redirect_count}, 32'h7);
        JumpOP = 2'd3; stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("stall_rdy_pc", pc, 32'h2000);
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) step();
        chk("stall_nrdy_pc", pc, 32'h2000);
        stall = 0;
        step();
        chk("nrdy_pc", pc, 32'h2000);
        chk("hold_rc", {16'h0, redirect_count}, 32'h7);
        fetch_ready = 1;
        step();
        chk("resume_pc", pc, 32'h2004);
        JumpOP = 2'd1; rs_data = 32'hFFFF_FFFC;
        step();
        chk("wrap_plus4", pc_plus4, 32'h0);
        JumpOP = 2'd3;
        step();
        chk("wrap_pc", pc, 32'h0);
        step();
        chk("pre_fault_pc", pc, 32'h4);
        JumpOP = 2'd1; rs_data = 32'h2002;
        step();
        chk("fault_pc_hold", pc, 32'h4);
        chk("fault_flag", {31'h0, fault}, 32'h1);
        chk("fault_addr", fault_pc, 32'h2002);
        chk("fault_freq", {31'h0, fetch_req}, 32'h0);
        chk("fault_rc", {16'h0, redirect_count}, 32'h8);
        rs_data = 32'h3000;
        for (int i = 0; i < 4; i++) step();
        chk("fault_sticky", {31'h0, fault}, 32'h1);
        chk("fault_sticky_pc", pc, 32'h4);
        chk("fault_sticky_rc", {16'h0, redirect_count}, 32'h8);
        #2 rst = 1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_fault", {31'h0, fault}, 32'h0);
        chk("async_fpc", fault_pc, 32'h0);
        chk("async_rc", {16'h0, redirect_count}, 32'h0);
        chk("async_freq", {31'h0, fetch_req}, 32'h0);
        step();
        rst = 0; JumpOP = 2'd1; rs_data = 32'h40;
        step();
        chk("first_edge_pc", pc, 32'h0);
        JumpOP = 2'd2; ins = 32'h0000_FFFF;
        for (int i = 0; i < 65535; i++) step();
        chk("sat_rc", {16'h0, redirect_count}, 32'hFFFF);
        chk("self_loop_pc", pc, 32'h0);
        step();
        chk("sat_hold", {16'h0, redirect_count}, 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
